csync_gen: RTL and testbench
============================

# csync_gen

Parametrised composite-sync generator for the Atari video path. It takes the console's separate HSYNC and VSYNC, synchronises them into the `clk` domain, measures line period and HSYNC width, and drives a registered CSYNC. In addition to the plain XOR-style combine, it can insert half-line serration pulses during VSYNC once the line timing is locked. It sits between the TIA sync outputs and the video connector/encoder.

## Interface
- `SYNC_STAGES`, default 2: synchroniser flops per input (≥2).
- `CNT_W`, default 12: width of the line and pulse counters, and of `line_period`.
- `IN_ACTIVE_LOW`, default 1: `hsync`/`vsync` are asserted at logic 0.
- `OUT_ACTIVE_LOW`, default 1: `csync` is asserted at logic 0.
- `MODE`, default 1: 0 selects XOR combine only; 1 adds mid-line serration during VSYNC when locked.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `hsync` in 1: horizontal sync, asynchronous to `clk`.
- `vsync` in 1: vertical sync, asynchronous to `clk`.
- `csync` out 1: composite sync, registered.
- `locked` out 1: line period stable, registered.
- `line_period` out CNT_W: last measured line period in clk cycles, registered.

## Operation
- **Synchronisers.** Each input passes through `SYNC_STAGES` flops. `hs_a` and `vs_a` are the synchronised inputs normalised to active-high (inverted when `IN_ACTIVE_LOW`=1).
- **Edges.**
  - `hs_rise` is `hs_a` going 0→1 (previous-cycle compare).
  - `hs_fall` is `hs_a` going 1→0.
- **`line_cnt` (CNT_W).**
  - Cleared to 0 on the cycle `hs_rise` is seen.
  - Otherwise increments, saturating at 2^CNT_W−1.
  - On `hs_rise`, the measured period is P = `line_cnt`+1.
- **`wid_cnt` (CNT_W).**
  - Cleared on `hs_rise`.
  - Increments while `hs_a`=1, saturating.
  - On `hs_fall`, W is latched as `wid_cnt`+1.
- **Lock FSM** (transitions only on `hs_rise`):
  - SEARCH: the first `hs_rise` goes to TRACK. No period is stored, because the first measurement is partial.
  - TRACK: store P in `line_period`. If P equals the previously stored P and `line_cnt` was not saturated, go to LOCKED; else stay in TRACK.
  - LOCKED: if P differs or `line_cnt` was saturated, store the new P and go to TRACK. `locked`=1 only in LOCKED.
  - If `line_cnt` saturates while LOCKED, go to SEARCH immediately, without waiting for `hs_rise`.
- **Composite combine** (`comp` is active-high):
  - `vs_a`=0: `comp` = `hs_a`.
  - `vs_a`=1 and (`MODE`=0 or not LOCKED): `comp` = NOT `hs_a`.
  - `vs_a`=1, `MODE`=1, LOCKED: `comp` = NOT (`hs_a` OR mid), where mid = (`line_cnt` ≥ H) AND (`line_cnt` < H+W), with H = `line_period`>>1.
  - Where the mid window overlaps the `hs_a` window, the two are ORed; there is no other special case.
  - Arithmetic for H+W is CNT_W+1 bits wide, so there is no wrap.
- **Output.** `csync` <= `comp` XOR `OUT_ACTIVE_LOW`.

## Timing
- Reset values:
  - `csync` = `OUT_ACTIVE_LOW` (inactive).
  - `locked` = 0; `line_period` = 0.
  - FSM = SEARCH; counters = 0; synchroniser flops = inactive level.
- Latency from an input edge to a `csync` change is `SYNC_STAGES`+1 rising edges; this is 3 with defaults.
- `line_period` and `locked` update on the clock edge following the `hs_rise` cycle.
- A VSYNC change takes effect at the same latency as HSYNC. A VSYNC edge mid-line switches the combine rule immediately; there is no line-alignment.
- If `hs_rise` and a `vs_a` change occur in the same cycle, `comp` uses the new `vs_a` value with `hs_a`=1.
- When `rst` is asserted mid-line, outputs go to their reset values asynchronously. After release, the first `hs_rise` restarts from SEARCH, and `locked` cannot reassert before the third `hs_rise`.

## Test plan
- **Reset and idle.** Assert `rst`, with both inputs held at 1 → `csync`=1, `locked`=0, `line_period`=0; these hold through 20 idle clocks after release.
- **Lock acquisition.** Lines of 10 clk high then 2 clk low hsync, `vsync`=1 → `line_period`=12 after the 2nd `hs_rise`, `locked`=1 after the 3rd.
- **Normal line, not in VSYNC.** Hsync low for 2 clk → `csync` low for exactly 2 clk, delayed 3 clk from the input.
- **VSYNC, `MODE`=0.** `vsync`=0 for 2 lines → `csync` low except a 2-clk high pulse per line aligned to hsync (+3 clk).
- **VSYNC, `MODE`=1, locked, P=12, W=2.** `csync` has additional 2-clk high pulses at `line_cnt` 6–7 in every line; with `locked`=0, only the hsync-aligned pulses appear.
- **Period change and saturation.** Change the line to 14 clk → `locked` drops, `line_period`=14, relock occurs after 2 matching lines. Stop hsync for 2^CNT_W clk → `locked`=0 and FSM returns to SEARCH.

Source files
------------

// File: rtl/csync_gen.sv
// csync_gen: composite-sync generator for the Atari video path.
// Takes separate HSYNC/VSYNC from the console and resynchronises them into
// clk. It measures the line period and the HSYNC width, then drives a
// registered CSYNC. During VSYNC it either inverts HSYNC (XOR combine) or,
// when MODE=1 and the line timing is locked, also inserts half-line
// serration pulses.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   hsync        horizontal sync, asynchronous to clk
//   vsync        vertical sync, asynchronous to clk
//   csync        composite sync output, registered
//   locked       line period stable, registered
//   line_period  last measured line period in clk cycles, registered
//
// Lock FSM states:
//   state  | meaning
//   SEARCH | no valid measurement yet; the first hs_rise only arms tracking
//   TRACK  | period stored, waiting for an identical consecutive period
//   LOCKED | period stable; serration allowed when MODE=1

module csync_gen #(
    parameter int SYNC_STAGES    = 2,
    parameter int CNT_W          = 12,
    parameter bit IN_ACTIVE_LOW  = 1'b1,
    parameter bit OUT_ACTIVE_LOW = 1'b1,
    parameter bit MODE           = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hsync,
    input  logic             vsync,
    output logic             csync,
    output logic             locked,
    output logic [CNT_W-1:0] line_period
);

    typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

    localparam logic             IN_IDLE = IN_ACTIVE_LOW;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [SYNC_STAGES-1:0] hs_sync;
    logic [SYNC_STAGES-1:0] vs_sync;
    logic                   hs_a;
    logic                   vs_a;
    logic                   hs_d;
    logic                   hs_rise;
    logic                   hs_fall;
    logic [CNT_W-1:0]       line_cnt;
    logic [CNT_W-1:0]       wid_cnt;
    logic [CNT_W-1:0]       wid_len;
    logic                   line_sat;
    logic [CNT_W-1:0]       period_meas;
    logic [CNT_W:0]         half;
    logic [CNT_W:0]         mid_end;
    logic                   mid;
    logic                   comp;
    state_t                 state;
    state_t                 state_nxt;
    logic [CNT_W-1:0]       period_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_sync <= {SYNC_STAGES{IN_IDLE}};
            vs_sync <= {SYNC_STAGES{IN_IDLE}};
        end else begin
            hs_sync <= {hs_sync[SYNC_STAGES-2:0], hsync};
            vs_sync <= {vs_sync[SYNC_STAGES-2:0], vsync};
        end
    end

    assign hs_a = hs_sync[SYNC_STAGES-1] ^ IN_ACTIVE_LOW;
    assign vs_a = vs_sync[SYNC_STAGES-1] ^ IN_ACTIVE_LOW;

    assign hs_rise     = hs_a & ~hs_d;
    assign hs_fall     = ~hs_a & hs_d;
    assign line_sat    = (line_cnt == CNT_MAX);
    // A saturated count wraps to 0 here; such a period is never trusted for lock.
    assign period_meas = line_cnt + CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_d     <= 1'b0;
            line_cnt <= '0;
            wid_cnt  <= '0;
            wid_len  <= '0;
        end else begin
            hs_d <= hs_a;
            if (hs_rise)
                line_cnt <= '0;
            else if (!line_sat)
                line_cnt <= line_cnt + CNT_W'(1);
            if (hs_rise)
                wid_cnt <= '0;
            else if (hs_a && (wid_cnt != CNT_MAX))
                wid_cnt <= wid_cnt + CNT_W'(1);
            if (hs_fall)
                wid_len <= wid_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        state_nxt  = state;
        period_nxt = line_period;
        case (state)
            SEARCH: begin
                if (hs_rise)
                    state_nxt = TRACK;
            end
            TRACK: begin
                if (hs_rise) begin
                    period_nxt = period_meas;
                    if ((period_meas == line_period) && !line_sat)
                        state_nxt = LOCKED;
                end
            end
            LOCKED: begin
                if (hs_rise) begin
                    if ((period_meas != line_period) || line_sat) begin
                        period_nxt = period_meas;
                        state_nxt  = TRACK;
                    end
                end else if (line_sat) begin
                    // hsync has gone away; start over rather than wait for an edge
                    state_nxt = SEARCH;
                end
            end
            default: state_nxt = SEARCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= SEARCH;
            line_period <= '0;
            locked      <= 1'b0;
        end else begin
            state       <= state_nxt;
            line_period <= period_nxt;
            locked      <= (state_nxt == LOCKED);
        end
    end

    // Serration window starts at half a line; one extra bit keeps H+W from wrapping.
    assign half    = {1'b0, (line_period >> 1)};
    assign mid_end = half + {1'b0, wid_len};
    assign mid     = ({1'b0, line_cnt} >= half) && ({1'b0, line_cnt} < mid_end);

    always_comb begin
        comp = hs_a;
        if (vs_a) begin
            if (MODE && (state == LOCKED))
                comp = ~(hs_a | mid);
            else
                comp = ~hs_a;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            csync <= OUT_ACTIVE_LOW;
        else
            csync <= comp ^ OUT_ACTIVE_LOW;
    end

endmodule

// File: tb/tb_csync_gen.sv
// Testbench for csync_gen: two instances (MODE=1 and MODE=0) share the same
// hsync/vsync stimulus. Stimulus pushes hand-derived expectations, tagged
// with the cycle they are due, into a scoreboard queue; a negedge monitor
// pops and compares them.

module tb_csync_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hsync = 1'b1;
    logic        vsync = 1'b1;
    logic        csync1, locked1;
    logic        csync0, locked0;
    logic [11:0] lp1, lp0;

    typedef struct {
        int due;
        bit cs1;
        bit cs0;
        bit chk_lk;
        bit lk;
        bit chk_lp;
        int lp;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    csync_gen #(.MODE(1'b1)) dut1 (
        .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync),
        .csync(csync1), .locked(locked1), .line_period(lp1)
    );

    csync_gen #(.MODE(1'b0)) dut0 (
        .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync),
        .csync(csync0), .locked(locked0), .line_period(lp0)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp)
            n_pass++;
        else
            $display("FAIL %s cyc=%0d got %0d expected %0d", nm, cyc, act, exp);
    endtask

    // Monitor: compare every scoreboard entry that falls due this cycle.
    always @(negedge clk) begin : monitor
        int   idx;
        exp_t e;
        idx = 0;
        while (idx < sb.size()) begin
            if (sb[idx].due == cyc) begin
                e = sb[idx];
                sb.delete(idx);
                chk("csync_mode1", int'(csync1), int'(e.cs1));
                chk("csync_mode0", int'(csync0), int'(e.cs0));
                if (e.chk_lk) begin
                    chk("locked_mode1", int'(locked1), int'(e.lk));
                    chk("locked_mode0", int'(locked0), int'(e.lk));
                end
                if (e.chk_lp) begin
                    chk("line_period_mode1", int'(lp1), e.lp);
                    chk("line_period_mode0", int'(lp0), e.lp);
                end
            end else begin
                idx++;
            end
        end
    end

    // Drive one cycle of inputs; its effect is visible on csync 3 edges later.
    task automatic step(input bit h, input bit v, input bit cs1, input bit cs0,
                        input bit chk_lk, input bit lk, input bit chk_lp, input int lp);
        exp_t e;
        @(posedge clk);
        #1;
        hsync = h;
        vsync = v;
        e.due    = cyc + 3;
        e.cs1    = cs1;
        e.cs0    = cs0;
        e.chk_lk = chk_lk;
        e.lk     = lk;
        e.chk_lp = chk_lp;
        e.lp     = lp;
        sb.push_back(e);
    endtask

    task automatic idle(input int n, input bit chk_lk, input bit lk, input int lp);
        for (int i = 0; i < n; i++)
            step(1'b1, 1'b1, 1'b1, 1'b1, chk_lk, lk, 1'b1, lp);
    endtask

    // One line: hsync low (active) for 'low' cycles, then high. v is the vsync
    // level (0 = active). lk/lp are the values expected after this line's
    // leading hs_rise; mid_lo..mid_hi are the line offsets of the serration
    // pulse expected on the MODE=1 instance.
    task automatic line(input int len, input int low, input bit v, input bit lk,
                        input int lp, input int mid_lo, input int mid_hi);
        bit hact;
        bit m;
        bit c1;
        bit c0;
        for (int i = 0; i < len; i++) begin
            hact = (i < low);
            m    = (i >= mid_lo) && (i <= mid_hi);
            if (v) begin
                c0 = !hact;
                c1 = !hact;
            end else begin
                c0 = hact;
                c1 = hact | m;
            end
            step(!hact, v, c1, c0, 1'b1, lk, 1'b1, lp);
        end
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog cyc=%0d got timeout expected finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        exp_t e;
        // reset with both inputs inactive, then idle
        idle(4, 1'b1, 1'b0, 0);
        rst = 1'b0;
        idle(20, 1'b1, 1'b0, 0);

        // lock acquisition, normal lines outside VSYNC
        line(12, 2, 1'b1, 1'b0, 0,  -1, -2);
        line(12, 2, 1'b1, 1'b0, 12, -1, -2);
        line(12, 2, 1'b1, 1'b1, 12, -1, -2);
        line(12, 2, 1'b1, 1'b1, 12, -1, -2);

        // VSYNC while locked: serration at line_cnt 6..7 -> offsets 7..8
        line(12, 2, 1'b0, 1'b1, 12, 7, 8);
        line(12, 2, 1'b0, 1'b1, 12, 7, 8);

        // period change to 14; VSYNC during the unlocked line -> no serration
        line(14, 2, 1'b1, 1'b1, 12, -1, -2);
        line(14, 2, 1'b0, 1'b0, 14, -1, -2);
        line(14, 2, 1'b1, 1'b1, 14, -1, -2);
        line(14, 2, 1'b0, 1'b1, 14, 8, 9);
        line(14, 2, 1'b1, 1'b1, 14, -1, -2);

        // hsync stops: line_cnt saturates and lock is lost
        idle(4150, 1'b0, 1'b0, 14);
        idle(50, 1'b1, 1'b0, 14);

        // back in SEARCH: first rise stores nothing
        line(12, 2, 1'b1, 1'b0, 14, -1, -2);
        line(12, 2, 1'b1, 1'b0, 12, -1, -2);
        line(12, 2, 1'b1, 1'b1, 12, -1, -2);
        line(12, 2, 1'b0, 1'b1, 12, 7, 8);

        // reset asserted mid-line during VSYNC
        line(5, 2, 1'b0, 1'b1, 12, 7, 8);
        sb.delete();
        rst   = 1'b1;
        hsync = 1'b1;
        vsync = 1'b1;
        e.due = cyc; e.cs1 = 1'b1; e.cs0 = 1'b1;
        e.chk_lk = 1'b1; e.lk = 1'b0; e.chk_lp = 1'b1; e.lp = 0;
        sb.push_back(e);
        idle(3, 1'b1, 1'b0, 0);
        rst = 1'b0;
        idle(5, 1'b1, 1'b0, 0);

        // relock after reset needs the third hs_rise
        line(12, 2, 1'b1, 1'b0, 0,  -1, -2);
        line(12, 2, 1'b1, 1'b0, 12, -1, -2);
        line(12, 2, 1'b1, 1'b1, 12, -1, -2);
        idle(4, 1'b1, 1'b1, 12);

        repeat (10) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        chk("scoreboard_drain", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
